// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID register, with branch redirect, decode back-pressure and HALT.
module fetch_stage #(
    parameter int                     PC_WIDTH    = 6,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    pcout,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic                   ifid_valid
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PC_WIDTH-1:0]    pc_d;
    logic [INSTR_WIDTH-1:0] instr_d;
    logic [PC_WIDTH-1:0]    ifid_pc_d;
    logic                   vld_d;
    logic                   is_halt;

    // Unsigned increment with silent wrap at 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_WIDTH'(1);
    endfunction

    assign is_halt   = (imem_data == HALT_WORD);
    assign imem_addr = pcout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!branch_taken && !stall && is_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (branch_taken) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // A branch squashes whatever was fetched this cycle, even under stall.
    always_comb begin
        pc_d      = pcout;
        instr_d   = ifid_instr;
        ifid_pc_d = ifid_pc;
        vld_d     = ifid_valid;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d  = branch_target;
                    vld_d = 1'b0;
                end else if (!stall) begin
                    instr_d   = imem_data;
                    ifid_pc_d = pcout;
                    vld_d     = 1'b1;
                    if (!is_halt) begin
                        pc_d = pc_inc(pcout);
                    end
                end
            end
            ST_HALT: begin
                if (branch_taken) begin
                    pc_d  = branch_target;
                    vld_d = 1'b0;
                end else if (!stall) begin
                    vld_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // IF/ID register boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcout      <= '0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else begin
            pcout      <= pc_d;
            ifid_instr <= instr_d;
            ifid_pc    <= ifid_pc_d;
            ifid_valid <= vld_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table replayed through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_fetch_stage;

    localparam int PC_W = 6;
    localparam int IW   = 32;
    localparam logic [IW-1:0] HW = 32'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_data;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] pcout;
    logic [IW-1:0]   ifid_instr;
    logic [PC_W-1:0] ifid_pc;
    logic            ifid_valid;

    logic [IW-1:0] imem [64];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            stall;
        logic            br;
        logic [PC_W-1:0] tgt;
        logic [PC_W-1:0] pc;
        logic            v;
        logic            chk_data;
        logic [PC_W-1:0] ipc;
        logic [IW-1:0]   instr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    fetch_stage #(.PC_WIDTH(PC_W), .INSTR_WIDTH(IW), .HALT_WORD(HW)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pcout        (pcout),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_valid   (ifid_valid)
    );

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    function automatic logic [IW-1:0] word_at(input int a);
        if (a < 4)  return IW'(10 + a);
        if (a == 7) return HW;
        return IW'(32'h1000 + a);
    endfunction

    function automatic vec_t mk(input logic s, input logic b, input int t, input int pc,
                                input logic v, input logic cd, input int ipc, input logic [IW-1:0] ins);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = PC_W'(t); r.pc = PC_W'(pc);
        r.v = v; r.chk_data = cd; r.ipc = PC_W'(ipc); r.instr = ins;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pcout"}, -1, IW'(pcout), '0);
        chk({name, "_imem_addr"}, -1, IW'(imem_addr), '0);
        chk({name, "_ifid_instr"}, -1, ifid_instr, '0);
        chk({name, "_ifid_pc"}, -1, IW'(ifid_pc), '0);
        chk({name, "_ifid_valid"}, -1, IW'(ifid_valid), '0);
    endtask

    // Drive one vector, queue its expectation, compare after the edge.
    task automatic step(input vec_t x, input int idx);
        vec_t e;
        stall = x.stall; branch_taken = x.br; branch_target = x.tgt;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
        end else begin
            e = sb.pop_front();
            chk("pcout", idx, IW'(pcout), IW'(e.pc));
            chk("imem_addr", idx, IW'(imem_addr), IW'(e.pc));
            chk("ifid_valid", idx, IW'(ifid_valid), IW'(e.v));
            if (e.chk_data) begin
                chk("ifid_pc", idx, IW'(ifid_pc), IW'(e.ipc));
                chk("ifid_instr", idx, ifid_instr, e.instr);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = word_at(i);
        stall = 0; branch_taken = 0; branch_target = '0;
        reset = 1'b1;

        // Boot ignores stall/branch; then sequential fetch, stall at 5, halt at 7,
        // resume via branch, branch under stall, wrap, and run up to pc=20.
        vecs.push_back(mk(1,1,33, 0,0,1, 0,'0));
        vecs.push_back(mk(0,0,0,  1,1,1, 0,word_at(0)));
        vecs.push_back(mk(0,0,0,  2,1,1, 1,word_at(1)));
        vecs.push_back(mk(0,0,0,  3,1,1, 2,word_at(2)));
        vecs.push_back(mk(0,0,0,  4,1,1, 3,word_at(3)));
        vecs.push_back(mk(0,0,0,  5,1,1, 4,word_at(4)));
        vecs.push_back(mk(1,0,0,  5,1,1, 4,word_at(4)));
        vecs.push_back(mk(1,0,0,  5,1,1, 4,word_at(4)));
        vecs.push_back(mk(1,0,0,  5,1,1, 4,word_at(4)));
        vecs.push_back(mk(0,0,0,  6,1,1, 5,word_at(5)));
        vecs.push_back(mk(0,0,0,  7,1,1, 6,word_at(6)));
        vecs.push_back(mk(0,0,0,  7,1,1, 7,HW));
        vecs.push_back(mk(0,0,0,  7,0,0, 0,'0));
        vecs.push_back(mk(0,0,0,  7,0,0, 0,'0));
        vecs.push_back(mk(1,0,0,  7,0,0, 0,'0));
        vecs.push_back(mk(0,1,2,  2,0,0, 0,'0));
        vecs.push_back(mk(0,0,0,  3,1,1, 2,word_at(2)));
        vecs.push_back(mk(1,1,40, 40,0,0, 0,'0));
        vecs.push_back(mk(0,0,0,  41,1,1, 40,word_at(40)));
        vecs.push_back(mk(0,1,62, 62,0,0, 0,'0));
        vecs.push_back(mk(0,0,0,  63,1,1, 62,word_at(62)));
        vecs.push_back(mk(0,0,0,  0,1,1, 63,word_at(63)));
        vecs.push_back(mk(0,0,0,  1,1,1, 0,word_at(0)));
        vecs.push_back(mk(0,1,18, 18,0,0, 0,'0));
        vecs.push_back(mk(0,0,0,  19,1,1, 18,word_at(18)));
        vecs.push_back(mk(0,0,0,  20,1,1, 19,word_at(19)));

        #12;
        chk_all_zero("in_reset");
        #10;
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i], i);

        // Asynchronous reset between edges at pcout=20.
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        chk_all_zero("held_reset");
        #2;
        reset = 1'b0;
        step(mk(0,0,0, 0,0,1, 0,'0),        100);
        step(mk(0,0,0, 1,1,1, 0,word_at(0)), 101);
        step(mk(0,0,0, 2,1,1, 1,word_at(1)), 102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
